reg_file_seq: RTL

- Initiator-side sequencer for `reg_file`. It drives `SA`/`DA`/`As`/`RW`/`Din` and captures `Sout`/`Dout`.
- Executes one register-operand instruction per `start`:
  - read source and destination;
  - apply `@Rn+` autoincrement write-back;
  - hand operands to the ALU and wait for its result;
  - write the result to the destination register.
- Sits between the instruction decoder and `reg_file`. It is the only module that asserts `RW`.

---
 rtl/reg_file_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/reg_file_seq.sv
// Initiator-side sequencer for reg_file: reads both operands, optionally writes back an
// @Rn+ autoincrement, waits for the ALU result, then writes the result to the destination.
module reg_file_seq #(
  parameter int unsigned INC_WORD = 2,
  parameter int unsigned INC_BYTE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  ins_sa,
  input  logic [3:0]  ins_da,
  input  logic [1:0]  ins_as,
  input  logic        ins_bw,
  input  logic        ins_wb,
  input  logic [15:0] Sout,
  input  logic [15:0] Dout,
  input  logic [15:0] alu_res,
  input  logic        res_valid,
  output logic [3:0]  SA,
  output logic [3:0]  DA,
  output logic [1:0]  As,
  output logic        RW,
  output logic [15:0] Din,
  output logic [15:0] src_op,
  output logic [15:0] dst_op,
  output logic        op_valid,
  output logic        busy,
  output logic        done
);

  // state | meaning
  // IDLE  | waiting for start
  // READ  | present SA/DA, capture Sout/Dout
  // INC   | write autoincremented source back to Rsa
  // OPV   | operands valid, waiting for res_valid
  // WB    | write ALU result to Rda
  // DONE  | one-cycle completion pulse
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_INC  = 3'd2;
  localparam logic [2:0] S_OPV  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [3:0]  sa_q, da_q;
  logic [1:0]  as_q;
  logic        bw_q, wb_q;
  logic [15:0] src_q, dst_q;
  logic        inc_en;
  logic [15:0] inc_step;
  logic [15:0] wb_data;

  // R2/R3 in mode 11 are the constant generator and are never incremented
  assign inc_en   = (as_q == 2'b11) && (sa_q[3:1] != 3'b001);
  assign inc_step = (bw_q && (sa_q >= 4'd4)) ? 16'(INC_BYTE) : 16'(INC_WORD);
  assign wb_data  = bw_q ? {8'h00, alu_res[7:0]} : alu_res;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_READ;
      S_READ:  state_d = inc_en ? S_INC : S_OPV;
      S_INC:   state_d = S_OPV;
      S_OPV:   if (res_valid) state_d = wb_q ? S_WB : S_DONE;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      da_q    <= '0;
      as_q    <= '0;
      bw_q    <= 1'b0;
      wb_q    <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        sa_q <= ins_sa;
        da_q <= ins_da;
        as_q <= ins_as;
        bw_q <= ins_bw;
        wb_q <= ins_wb;
      end
      if (state_q == S_READ) begin
        src_q <= Sout;
        dst_q <= Dout;
      end
    end
  end

  always_comb begin
    RW  = 1'b0;
    DA  = da_q;
    Din = '0;
    case (state_q)
      S_INC: begin
        RW  = 1'b1;
        DA  = sa_q;
        Din = src_q + inc_step;
      end
      S_WB: begin
        RW  = 1'b1;
        Din = wb_data;
      end
      default: ;
    endcase
  end

  assign SA       = sa_q;
  assign As       = as_q;
  assign src_op   = src_q;
  assign dst_op   = dst_q;
  assign op_valid = (state_q == S_OPV);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule
